// File: rtl/ps2_key_event_gen.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw lines, shifts 11-bit frames
// and turns scancode bytes into the 11-bit ps2_key event word.

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic line_flt
);
    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // Level only moves once the synced line has disagreed for FILTER_LEN samples in a row
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            line_flt <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_in};
            if (sync_q[1] == line_flt) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                line_flt <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

module ps2_key_event_gen #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 10816
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);
    localparam int NUM_LINES = 2;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

    logic [NUM_LINES-1:0] raw_lines, flt_lines;
    logic                 clk_flt_q, strobe, bit_data;
    state_t               state_q, state_d;
    logic [9:0]           shreg_q;
    logic [3:0]           bitcnt_q;
    logic [15:0]          to_cnt_q;
    logic                 to_hit, frame_ok, byte_valid;
    logic [7:0]           rx_byte;
    logic                 rel_q, ext_q;
    logic [2:0]           skip_q;

    assign raw_lines = {ps2_data_in, ps2_clk_in};

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_flt (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .line_in  (raw_lines[i]),
            .line_flt (flt_lines[i])
        );
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) clk_flt_q <= 1'b1;
        else          clk_flt_q <= flt_lines[0];
    end

    assign strobe   = clk_flt_q & ~flt_lines[0];
    assign bit_data = flt_lines[1];
    assign to_hit   = (to_cnt_q == 16'(TIMEOUT - 1));
    assign rx_byte  = shreg_q[7:0];
    // shreg holds {stop, parity, data[7:0]} once all ten post-start bits are in
    assign frame_ok = (^shreg_q[8:0]) & shreg_q[9];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (strobe && !bit_data) state_d = S_SHIFT;
            S_SHIFT: begin
                if (strobe) begin
                    if (bitcnt_q == 4'd10) state_d = S_CHECK;
                end else if (to_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        byte_valid = (state_q == S_CHECK) & frame_ok;
        frame_err  = ((state_q == S_CHECK) & ~frame_ok)
                   | ((state_q == S_SHIFT) & ~strobe & to_hit);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            if (state_q != S_SHIFT || strobe) to_cnt_q <= '0;
            else                              to_cnt_q <= to_cnt_q + 16'd1;
            if (state_q == S_IDLE && strobe && !bit_data) begin
                bitcnt_q <= 4'd1;
            end else if (state_q == S_SHIFT && strobe) begin
                bitcnt_q <= bitcnt_q + 4'd1;
                shreg_q  <= {bit_data, shreg_q[9:1]};
            end
        end
    end

    // Prefix bytes (E0/F0/E1) only arm state; skip swallows the rest of the Pause sequence
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_key <= '0;
            rel_q   <= 1'b0;
            ext_q   <= 1'b0;
            skip_q  <= '0;
        end else if (byte_valid) begin
            if (skip_q != 3'd0) begin
                skip_q <= skip_q - 3'd1;
            end else begin
                case (rx_byte)
                    8'hE1: begin
                        skip_q <= 3'd7;
                        rel_q  <= 1'b0;
                        ext_q  <= 1'b0;
                    end
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: rel_q <= 1'b1;
                    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
                        rel_q <= 1'b0;
                        ext_q <= 1'b0;
                    end
                    default: begin
                        ps2_key <= {~ps2_key[10], ~rel_q, ext_q, rx_byte};
                        rel_q   <= 1'b0;
                        ext_q   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Bench for ps2_key_event_gen: directed vector table, multi-cycle corner sequences and
// random frames checked against a byte-stream model of the key decoder.

module tb_ps2_key_event_gen;
    localparam int FL = 8;
    localparam int TO = 10816;
    localparam int H  = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    ps2_key_event_gen #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;

    // Observer: error pulses, busy falling edges and what was visible at them
    int          err_total = 0, fall_cnt = 0, overlap_cnt = 0;
    logic [10:0] fall_key = '0, prev_key = '0;
    logic        fall_err = 1'b0, prev_busy = 1'b0, prev_err = 1'b0;

    always @(negedge clk_sys) begin
        if (frame_err) err_total++;
        if (frame_err && ps2_key !== prev_key) overlap_cnt++;
        if (prev_busy && !busy) begin
            fall_cnt++;
            fall_key = ps2_key;
            fall_err = prev_err;
        end
        prev_busy = busy;
        prev_err  = frame_err;
        prev_key  = ps2_key;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Reference model: key word kept as separate fields, driven by the accepted byte stream
    bit       m_toggle, m_pressed, m_ext_out, m_rel, m_ext;
    bit [7:0] m_code;
    int       m_skip;

    function automatic logic [10:0] m_key();
        return {m_toggle, m_pressed, m_ext_out, m_code};
    endfunction

    task automatic model_reset();
        m_toggle = 0; m_pressed = 0; m_ext_out = 0; m_code = 0;
        m_rel = 0; m_ext = 0; m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] responses [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
        bit is_resp = 0;
        foreach (responses[i]) if (responses[i] == b) is_resp = 1;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) begin m_skip = 7; m_rel = 0; m_ext = 0; end
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else if (is_resp) begin m_rel = 0; m_ext = 0; end
        else begin
            m_toggle  = !m_toggle;
            m_pressed = !m_rel;
            m_ext_out = m_ext;
            m_code    = b;
            m_rel = 0; m_ext = 0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_in = fr[i];
            cyc(H);
            ps2_clk_in = 1'b0;
            cyc(H);
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bp, input bit bs,
                            input logic [10:0] ek, input bit ee);
        int e0, f0;
        e0 = err_total;
        f0 = fall_cnt;
        send_bits(b, bp, bs, 11);
        cyc(40);
        check("busy_episode", 32'(fall_cnt - f0), 32'd1);
        check("err_pulses", 32'(err_total - e0), 32'(ee));
        check("err_in_check_cycle", 32'(fall_err), 32'(ee));
        check("key_at_busy_fall", 32'(fall_key), 32'(ek));
        check("key", 32'(ps2_key), 32'(ek));
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          bad;
        logic [10:0] key;
        bit          err;
    } vec_t;

    vec_t tbl [0:22];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            do_frame(tbl[i].b, tbl[i].bad, 1'b0, tbl[i].key, tbl[i].err);
            if (!tbl[i].bad) model_byte(tbl[i].b);
        end
    endtask

    initial begin
        int e0, f0, busy_seen, waited;
        logic [7:0] sp [8] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFE, 8'hEE};

        tbl[0]  = '{8'h1C, 1'b0, 11'h61C, 1'b0};
        tbl[1]  = '{8'hF0, 1'b0, 11'h61C, 1'b0};
        tbl[2]  = '{8'h1C, 1'b0, 11'h01C, 1'b0};
        tbl[3]  = '{8'hE0, 1'b0, 11'h01C, 1'b0};
        tbl[4]  = '{8'h75, 1'b0, 11'h775, 1'b0};
        tbl[5]  = '{8'hE0, 1'b0, 11'h775, 1'b0};
        tbl[6]  = '{8'hF0, 1'b0, 11'h775, 1'b0};
        tbl[7]  = '{8'h75, 1'b0, 11'h175, 1'b0};
        tbl[8]  = '{8'h29, 1'b1, 11'h175, 1'b1};
        tbl[9]  = '{8'h29, 1'b0, 11'h629, 1'b0};
        tbl[10] = '{8'hF0, 1'b0, 11'h629, 1'b0};
        tbl[11] = '{8'hAA, 1'b0, 11'h629, 1'b0};
        tbl[12] = '{8'h1C, 1'b0, 11'h21C, 1'b0};
        tbl[13] = '{8'h29, 1'b0, 11'h629, 1'b0};
        tbl[14] = '{8'hE1, 1'b0, 11'h629, 1'b0};
        tbl[15] = '{8'h14, 1'b0, 11'h629, 1'b0};
        tbl[16] = '{8'h77, 1'b0, 11'h629, 1'b0};
        tbl[17] = '{8'hE1, 1'b0, 11'h629, 1'b0};
        tbl[18] = '{8'hF0, 1'b0, 11'h629, 1'b0};
        tbl[19] = '{8'h14, 1'b0, 11'h629, 1'b0};
        tbl[20] = '{8'hF0, 1'b0, 11'h629, 1'b0};
        tbl[21] = '{8'h77, 1'b0, 11'h629, 1'b0};
        tbl[22] = '{8'h1C, 1'b0, 11'h21C, 1'b0};

        model_reset();
        cyc(3);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        cyc(5);

        run_rows(0, 12);

        // Partial frame then silence: abort by timeout
        e0 = err_total;
        send_bits(8'h29, 1'b0, 1'b0, 5);
        waited = 0;
        while (err_total == e0 && waited < TO + 200) begin
            cyc(1);
            waited++;
        end
        cyc(5);
        check("timeout_err_pulses", 32'(err_total - e0), 32'd1);
        check("timeout_busy", 32'(busy), 32'h0);
        check("timeout_key", 32'(ps2_key), 32'h21C);

        run_rows(13, 13);

        // Clock glitch one cycle shorter than the filter window
        f0 = fall_cnt;
        busy_seen = 0;
        ps2_clk_in = 1'b0;
        cyc(FL - 1);
        ps2_clk_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (busy) busy_seen++;
        end
        check("glitch_busy", 32'(busy_seen), 32'd0);
        check("glitch_no_frame", 32'(fall_cnt - f0), 32'd0);

        run_rows(14, 22);

        // Asynchronous reset in the middle of a frame
        e0 = err_total;
        send_bits(8'h1C, 1'b0, 1'b0, 4);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_key", 32'(ps2_key), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_err", 32'(frame_err), 32'h0);
        cyc(3);
        reset_n = 1'b1;
        model_reset();
        cyc(5);
        check("midreset_no_err", 32'(err_total - e0), 32'd0);
        do_frame(8'h1C, 1'b0, 1'b0, 11'h61C, 1'b0);
        model_byte(8'h1C);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit bp, bs;
            b  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 7)] : 8'($urandom);
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 19) == 0);
            if (!(bp || bs)) model_byte(b);
            do_frame(b, bp, bs, m_key(), bp || bs);
        end

        check("err_key_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
